// File: rtl/uart_ram_ctrl.sv
// UART receive buffer: stores received bytes in an external RAM and, on a key press,
// replays the stored bytes oldest-first through the UART transmitter, then empties the buffer.
module uart_ram_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WRAP   = 0,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        Rx_data,
  input  logic              Rx_done,
  input  logic              Dump_req,
  input  logic              Tx_busy,
  input  logic              Tx_done,
  output logic              Tx_en,
  output logic [7:0]        Tx_data,
  output logic              Ram_wren,
  output logic [ADDR_W-1:0] Ram_waddr,
  output logic [7:0]        Ram_wdata,
  output logic [ADDR_W-1:0] Ram_raddr,
  input  logic [7:0]        Ram_rdata,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Overflow,
  output logic              Dumping
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic        L_WRAP = (WRAP != 0);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ADDR  = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_TX_START = 3'd3;
  localparam logic [2:0] S_TX_WAIT  = 3'd4;
  localparam logic [2:0] S_CLEAR    = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_wrapped;
  logic              r_overflow;
  logic              r_lat_cnt;
  logic [7:0]        r_tx_data;

  logic              w_idle;
  logic              w_full;
  logic              w_wr;
  logic              w_lost;
  logic              w_start;
  logic              w_lat_done;
  logic              w_tx_en;
  logic [ADDR_W-1:0] w_wptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_wrapped_nxt;

  // Write-side bookkeeping; a byte arriving with a dump request is stored before the dump starts
  assign w_idle        = (r_state == S_IDLE);
  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign w_wr          = !Rst && w_idle && Rx_done && (!w_full || L_WRAP);
  assign w_lost        = Rx_done && (!w_idle || w_full);
  assign w_wptr_nxt    = w_wr ? (r_wptr + ADDR_W'(1)) : r_wptr;
  assign w_count_nxt   = (w_wr && !w_full) ? (r_count + CNT_W'(1)) : r_count;
  assign w_wrapped_nxt = r_wrapped | (w_wr & w_full);
  assign w_start       = w_idle && Dump_req && (w_count_nxt != '0);
  assign w_lat_done    = (r_lat_cnt == 1'(RD_LAT - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and transmit-strobe logic
  always_comb begin
    w_state_nxt = r_state;
    w_tx_en     = 1'b0;
    case (r_state)
      S_IDLE:     if (w_start) w_state_nxt = S_RD_ADDR;
      S_RD_ADDR:  w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (w_lat_done) w_state_nxt = S_TX_START;
      S_TX_START: begin
        if (!Tx_busy && !Rst) begin
          w_tx_en     = 1'b1;
          w_state_nxt = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (Tx_done) w_state_nxt = (r_remaining == CNT_W'(1)) ? S_CLEAR : S_RD_ADDR;
      end
      S_CLEAR:    w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer pointers, counters and transmit data
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_wrapped   <= 1'b0;
      r_overflow  <= 1'b0;
      r_lat_cnt   <= 1'b0;
      r_tx_data   <= '0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_count   <= w_count_nxt;
      r_wrapped <= w_wrapped_nxt;
      if (w_lost) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_rptr      <= w_wrapped_nxt ? w_wptr_nxt : '0;
            r_remaining <= w_count_nxt;
          end
        end
        S_RD_ADDR: r_lat_cnt <= 1'b0;
        S_RD_WAIT: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (w_lat_done) r_tx_data <= Ram_rdata;
        end
        S_TX_WAIT: begin
          if (Tx_done) begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_rptr      <= r_rptr + ADDR_W'(1);
          end
        end
        S_CLEAR: begin
          r_wptr    <= '0;
          r_rptr    <= '0;
          r_count   <= '0;
          r_wrapped <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign Tx_en     = w_tx_en;
  assign Tx_data   = r_tx_data;
  assign Ram_wren  = w_wr;
  assign Ram_waddr = r_wptr;
  assign Ram_wdata = Rx_data;
  assign Ram_raddr = r_rptr;
  assign Count     = r_count;
  assign Full      = w_full;
  assign Overflow  = r_overflow;
  assign Dumping   = !w_idle;

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// Bench for uart_ram_ctrl: a drop-when-full/RD_LAT=1 instance and an overwrite/RD_LAT=2 instance
// share stimulus; a queue-based buffer model feeds a scoreboard checked on every Tx_en.
module tb_uart_ram_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_done, dump, hold_busy;
  logic [7:0] rx_data;
  logic       tx_en [2], tx_busy [2], tx_done [2], full [2], ovf_o [2], dmp [2], wren [2];
  logic [7:0] tx_data [2];
  logic [2:0] cnt [2];
  logic [1:0] raddr [2];

  logic [7:0] mdl0 [$], mdl1 [$], exp0 [$], exp1 [$];
  logic       ovf_m [2];
  int         vecs, errs;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [1:0]  waddr;
    logic [7:0]  wdata, rdata, p1, p2;
    logic [7:0]  mem [4];
    logic        busy_m = 1'b0;
    logic        done_m = 1'b0;
    int unsigned tcnt = 0;

    uart_ram_ctrl #(.ADDR_W(2), .WRAP(g), .RD_LAT(g + 1)) u_dut (
      .Clk(clk), .Rst(rst), .Rx_data(rx_data), .Rx_done(rx_done), .Dump_req(dump),
      .Tx_busy(tx_busy[g]), .Tx_done(tx_done[g]), .Tx_en(tx_en[g]), .Tx_data(tx_data[g]),
      .Ram_wren(wren[g]), .Ram_waddr(waddr), .Ram_wdata(wdata), .Ram_raddr(raddr[g]),
      .Ram_rdata(rdata), .Count(cnt[g]), .Full(full[g]), .Overflow(ovf_o[g]), .Dumping(dmp[g]));

    // RAM with a read pipeline of g+1 cycles
    always @(posedge clk) begin
      if (wren[g] === 1'b1) mem[waddr] <= wdata;
      p1 <= mem[raddr[g]];
      p2 <= p1;
    end
    assign rdata = (g == 0) ? p1 : p2;

    // Transmitter: busy for a random number of cycles after each Tx_en, then a done pulse
    always @(posedge clk) begin
      done_m <= 1'b0;
      if (tx_en[g] === 1'b1) begin
        busy_m <= 1'b1;
        tcnt   <= $urandom_range(5, 1);
      end else if (busy_m) begin
        if (tcnt == 0) begin
          busy_m <= 1'b0;
          done_m <= 1'b1;
        end else tcnt <= tcnt - 1;
      end
    end
    assign tx_busy[g] = busy_m | hold_busy;
    assign tx_done[g] = done_m;
  end

  function automatic void chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, i, act, exp);
    end
  endfunction

  // Reference buffer: instance 0 drops when full, instance 1 discards the oldest byte
  function automatic void mdl_wr(logic [7:0] b);
    if (mdl0.size() < DEPTH) mdl0.push_back(b);
    else ovf_m[0] = 1'b1;
    if (mdl1.size() == DEPTH) begin
      mdl1.delete(0);
      ovf_m[1] = 1'b1;
    end
    mdl1.push_back(b);
  endfunction

  function automatic void mdl_dump();
    foreach (mdl0[k]) exp0.push_back(mdl0[k]);
    foreach (mdl1[k]) exp1.push_back(mdl1[k]);
    mdl0.delete();
    mdl1.delete();
  endfunction

  function automatic int mdl_cnt(int i);
    return (i == 0) ? mdl0.size() : mdl1.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (tx_en[i] === 1'b1) begin
          chk("tx_en_while_busy", i, 32'(tx_busy[i]), 0);
          if ((i == 0 ? exp0.size() : exp1.size()) == 0) chk("unexpected_tx_en", i, 32'(tx_en[i]), 0);
          else begin
            if (i == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            chk("tx_data", i, 32'(tx_data[i]), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic chk_state(string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_count"}, i, 32'(cnt[i]), mdl_cnt(i));
      chk({tag, "_full"}, i, 32'(full[i]), 32'(mdl_cnt(i) == DEPTH));
      chk({tag, "_overflow"}, i, 32'(ovf_o[i]), 32'(ovf_m[i]));
      chk({tag, "_dumping"}, i, 32'(dmp[i]), 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    mdl0.delete(); mdl1.delete(); exp0.delete(); exp1.delete();
    ovf_m = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      chk("rst_count", i, 32'(cnt[i]), 0);
      chk("rst_full", i, 32'(full[i]), 0);
      chk("rst_overflow", i, 32'(ovf_o[i]), 0);
      chk("rst_tx_en", i, 32'(tx_en[i]), 0);
      chk("rst_tx_data", i, 32'(tx_data[i]), 0);
      chk("rst_ram_wren", i, 32'(wren[i]), 0);
      chk("rst_ram_raddr", i, 32'(raddr[i]), 0);
      chk("rst_dumping", i, 32'(dmp[i]), 0);
    end
    rst = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, logic with_dump);
    rx_data = b; rx_done = 1'b1; dump = with_dump;
    mdl_wr(b);
    if (with_dump) mdl_dump();
    tick();
    rx_done = 1'b0; dump = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((dmp[0] || dmp[1] || exp0.size() != 0 || exp1.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("dump_timeout", 0, 32'(n < 3000), 1);
  endtask

  task automatic dump_lat();
    int first [2];
    first = '{-1, -1};
    dump = 1'b1;
    mdl_dump();
    for (int c = 1; c <= 8; c++) begin
      tick();
      dump = 1'b0;
      for (int i = 0; i < 2; i++)
        if (tx_en[i] === 1'b1 && first[i] < 0) first[i] = c;
    end
    for (int i = 0; i < 2; i++) chk("first_tx_latency", i, first[i], 3 + i);
  endtask

  task automatic dump_rand();
    logic started;
    started = (mdl0.size() != 0);
    dump = 1'b1;
    mdl_dump();
    tick();
    dump = 1'b0;
    if (started && $urandom_range(1, 0) == 1) begin
      rx_data = 8'($urandom); rx_done = 1'b1; dump = 1'($urandom_range(1, 0));
      ovf_m[0] = 1'b1; ovf_m[1] = 1'b1;
      tick();
      rx_done = 1'b0; dump = 1'b0;
    end
  endtask

  initial begin
    int   nb, nd, seen;
    logic merge;
    rst = 1'b1; rx_done = 1'b0; dump = 1'b0; hold_busy = 1'b0; rx_data = '0;
    vecs = 0; errs = 0; ovf_m = '{1'b0, 1'b0};
    fork monitor(); join_none
    repeat (3) tick();
    do_reset();

    // Four bytes, exact fill, first-byte latency per read latency
    send_byte(8'h5A, 1'b0); send_byte(8'hAA, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h77, 1'b0);
    chk_state("fill4");
    dump_lat();
    wait_done();
    chk_state("drain4");

    // Six bytes into a four-byte buffer
    for (int k = 1; k <= 6; k++) send_byte(8'(k), 1'b0);
    chk_state("over6");
    dump_rand();
    wait_done();
    chk_state("drain6");

    // Randomized fills, merged write+dump, writes and repeat requests during a dump
    for (int r = 0; r < 30; r++) begin
      nb = $urandom_range(6, 0);
      merge = 1'($urandom_range(1, 0));
      for (int k = 0; k < nb; k++) begin
        if (merge && k == nb - 1) send_byte(8'($urandom), 1'b1);
        else begin
          send_byte(8'($urandom), 1'b0);
          repeat ($urandom_range(2, 0)) tick();
        end
      end
      if (!(merge && nb > 0)) begin
        chk_state("rnd_fill");
        dump_rand();
      end
      wait_done();
      chk_state("rnd_drain");
    end

    // Transmitter held busy for 50 cycles after the request
    send_byte(8'hC3, 1'b0); send_byte(8'h3C, 1'b0);
    hold_busy = 1'b1; dump = 1'b1;
    mdl_dump();
    tick();
    dump = 1'b0;
    seen = 0;
    repeat (49) begin
      tick();
      if (tx_en[0] === 1'b1 || tx_en[1] === 1'b1) seen++;
    end
    chk("tx_en_during_busy", 0, seen, 0);
    hold_busy = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("tx_en_on_busy_fall", i, 32'(tx_en[i]), 1);
    wait_done();
    chk_state("busy_drain");

    // Reset after the second byte of a four-byte dump
    for (int k = 0; k < 4; k++) send_byte(8'($urandom), 1'b0);
    dump = 1'b1;
    mdl_dump();
    tick();
    dump = 1'b0;
    nd = 0;
    for (int c = 0; c < 500 && nd < 2; c++) begin
      tick();
      if (tx_done[0] === 1'b1) nd++;
    end
    chk("tx_done_before_reset", 0, nd, 2);
    do_reset();

    // Empty buffer: request ignored for 100 cycles
    dump = 1'b1;
    seen = 0; nd = 0;
    repeat (100) begin
      tick();
      dump = 1'b0;
      if (tx_en[0] === 1'b1 || tx_en[1] === 1'b1) seen++;
      if (dmp[0] !== 1'b0 || dmp[1] !== 1'b0) nd++;
    end
    chk("empty_dump_tx_en", 0, seen, 0);
    chk("empty_dump_dumping", 0, nd, 0);
    chk_state("empty");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
